// File: rtl/cpu_pkg.sv
// Shared core definitions: opcodes used by the writeback stage, the
// link register index, and the writeback FSM state type.
package cpu_pkg;

    localparam logic [5:0] OP_LDW     = 6'd8;
    localparam logic [5:0] OP_SDW     = 6'd9;
    localparam logic [5:0] OP_CLL     = 6'd15;

    localparam logic [3:0] RETURN_REG = 4'd14;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WB_HI = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_unit.sv
// Writeback stage: drives the register-file write port from retiring MEM/WB
// results. Sequences the two-cycle LDW writeback (rd, then rd+1), redirects
// CLL return-address writes to R14, and pulses exception for odd-destination
// double-word accesses. Busy only during the LDW high-word cycle.
//
// Optional build macro WB_FORWARD_EN: adds fwd_valid/fwd_rd/fwd_data, a
// combinational mirror of the registered write for EX-stage bypass.
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [OPC_W-1:0]  wb_opcode,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_mem_data0,
    input  logic [DATA_W-1:0] wb_mem_data1,
    input  logic [DATA_W-1:0] wb_return_addr,
    output logic              reg_write,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write_addr_sel,
    output logic              stall,
`ifdef WB_FORWARD_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              exception
);

    wb_state_e         r_state;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_write_data;
    logic              r_addr_sel;
    logic              r_exception;
    // High half of an LDW, captured at accept so upstream may change freely
    logic [REG_AW-1:0] r_hi_rd;
    logic [DATA_W-1:0] r_hi_data;

    logic              w_accept;
    logic              w_is_ldw;
    logic              w_is_sdw;
    logic              w_is_cll;
    logic              w_rd_odd;
    logic [DATA_W-1:0] w_std_data;

    // Decode of the retiring instruction and handshake
    always_comb begin
        wb_ready   = (r_state == IDLE);
        stall      = ~wb_ready;
        w_accept   = wb_valid && wb_ready;
        w_is_ldw   = (wb_opcode == OPC_W'(OP_LDW));
        w_is_sdw   = (wb_opcode == OPC_W'(OP_SDW));
        w_is_cll   = (wb_opcode == OPC_W'(OP_CLL));
        w_rd_odd   = wb_rd[0];
        w_std_data = wb_mem_to_reg ? wb_mem_data0 : wb_alu_result;
    end

    // FSM with registered register-file outputs; write strobes default low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
            r_addr_sel   <= 1'b0;
            r_exception  <= 1'b0;
            r_hi_rd      <= '0;
            r_hi_data    <= '0;
        end else begin
            r_reg_write <= 1'b0;
            r_addr_sel  <= 1'b0;
            r_exception <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_ldw) begin
                            if (w_rd_odd) begin
                                r_exception <= 1'b1;
                            end else begin
                                r_reg_write  <= 1'b1;
                                r_rd         <= wb_rd;
                                r_write_data <= wb_mem_data0;
                                // Even rd: +1 cannot wrap
                                r_hi_rd      <= wb_rd + REG_AW'(1);
                                r_hi_data    <= wb_mem_data1;
                                r_state      <= WB_HI;
                            end
                        end else if (w_is_sdw) begin
                            r_exception <= w_rd_odd;
                        end else if (w_is_cll) begin
                            r_reg_write  <= 1'b1;
                            r_rd         <= REG_AW'(RETURN_REG);
                            r_write_data <= wb_return_addr;
                            r_addr_sel   <= 1'b1;
                        end else begin
                            r_reg_write  <= wb_reg_write;
                            r_rd         <= wb_rd;
                            r_write_data <= w_std_data;
                        end
                    end
                end
                WB_HI: begin
                    r_reg_write  <= 1'b1;
                    r_rd         <= r_hi_rd;
                    r_write_data <= r_hi_data;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output port mapping
    always_comb begin
        reg_write          = r_reg_write;
        rd                 = r_rd;
        write_data         = r_write_data;
        reg_write_addr_sel = r_addr_sel;
        exception          = r_exception;
    end

`ifdef WB_FORWARD_EN
    // Bypass mirrors whatever the register file is being written with now
    always_comb begin
        fwd_valid = r_reg_write;
        fwd_rd    = r_rd;
        fwd_data  = r_write_data;
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed cases followed by a
// randomized transaction stream checked against a per-opcode reference model.
module tb_writeback_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [5:0]  wb_opcode;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [3:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data0;
    logic [31:0] wb_mem_data1;
    logic [31:0] wb_return_addr;
    logic        reg_write;
    logic [3:0]  rd;
    logic [31:0] write_data;
    logic        reg_write_addr_sel;
    logic        stall;
    logic        exception;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    writeback_unit #(.DATA_W(32), .REG_AW(4), .OPC_W(6)) dut (
        .clk                (clk),
        .reset              (reset),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_opcode          (wb_opcode),
        .wb_reg_write       (wb_reg_write),
        .wb_mem_to_reg      (wb_mem_to_reg),
        .wb_rd              (wb_rd),
        .wb_alu_result      (wb_alu_result),
        .wb_mem_data0       (wb_mem_data0),
        .wb_mem_data1       (wb_mem_data1),
        .wb_return_addr     (wb_return_addr),
        .reg_write          (reg_write),
        .rd                 (rd),
        .write_data         (write_data),
        .reg_write_addr_sel (reg_write_addr_sel),
        .stall              (stall),
`ifdef WB_FORWARD_EN
        .fwd_valid          (fwd_valid),
        .fwd_rd             (fwd_rd),
        .fwd_data           (fwd_data),
`endif
        .exception          (exception)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against one expected register-file cycle
    task automatic expect_out(input string tag, input bit we, input logic [3:0] r,
                              input logic [31:0] d, input bit sel, input bit exc,
                              input bit rdy);
        chk({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, we});
        chk({tag, ".exception"}, {31'd0, exception}, {31'd0, exc});
        chk({tag, ".addr_sel"}, {31'd0, reg_write_addr_sel}, {31'd0, sel});
        chk({tag, ".wb_ready"}, {31'd0, wb_ready}, {31'd0, rdy});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, ~rdy});
        if (we) begin
            chk({tag, ".rd"}, {28'd0, rd}, {28'd0, r});
            chk({tag, ".write_data"}, write_data, d);
        end
`ifdef WB_FORWARD_EN
        chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, we});
        if (we) begin
            chk({tag, ".fwd_rd"}, {28'd0, fwd_rd}, {28'd0, r});
            chk({tag, ".fwd_data"}, fwd_data, d);
        end
`endif
    endtask

    task automatic drive(input logic [5:0] opc, input bit rw, input bit m2r,
                         input logic [3:0] r, input logic [31:0] alu,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] ra);
        wb_valid       = 1'b1;
        wb_opcode      = opc;
        wb_reg_write   = rw;
        wb_mem_to_reg  = m2r;
        wb_rd          = r;
        wb_alu_result  = alu;
        wb_mem_data0   = d0;
        wb_mem_data1   = d1;
        wb_return_addr = ra;
    endtask

    // One retiring instruction; expectations follow the opcode rules directly
    task automatic xact(input logic [5:0] opc, input bit rw, input bit m2r,
                        input logic [3:0] r, input logic [31:0] alu,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] ra);
        logic [3:0] r_hi;
        r_hi = r + 4'd1;
        drive(opc, rw, m2r, r, alu, d0, d1, ra);
        tick();
        if (opc == 6'd8) begin
            if (r[0]) begin
                expect_out("ldw_odd", 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1);
            end else begin
                expect_out("ldw_lo", 1'b1, r, d0, 1'b0, 1'b0, 1'b0);
                wb_valid = 1'($urandom_range(0, 1));
                tick();
                expect_out("ldw_hi", 1'b1, r_hi, d1, 1'b0, 1'b0, 1'b1);
            end
        end else if (opc == 6'd9) begin
            expect_out("sdw", 1'b0, 4'd0, 32'd0, 1'b0, r[0], 1'b1);
        end else if (opc == 6'd15) begin
            expect_out("cll", 1'b1, 4'd14, ra, 1'b1, 1'b0, 1'b1);
        end else begin
            expect_out("alu", rw, r, m2r ? d0 : alu, 1'b0, 1'b0, 1'b1);
        end
        wb_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        drive(6'($urandom_range(0, 15)), 1'b1, 1'b0, 4'($urandom), $urandom, $urandom,
              $urandom, $urandom);
        wb_valid = 1'b0;
        tick();
        expect_out("idle", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [5:0] opc;
        reset = 1'b1;
        drive(6'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        wb_valid = 1'b0;
        tick();
        tick();
        expect_out("reset", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("reset.rd", {28'd0, rd}, 32'd0);
        chk("reset.write_data", write_data, 32'd0);
        reset = 1'b0;

        // ADD-class write, then hold of rd/write_data across an idle cycle
        xact(6'd0, 1'b1, 1'b0, 4'd1, 32'h12345678, 32'h0, 32'h0, 32'h0);
        wb_valid = 1'b0;
        tick();
        chk("hold.reg_write", {31'd0, reg_write}, 32'd0);
        chk("hold.rd", {28'd0, rd}, 32'd1);
        chk("hold.write_data", write_data, 32'h12345678);

        xact(6'd8, 1'b1, 1'b1, 4'd2, 32'h0, 32'hAAAA0000, 32'h0000BBBB, 32'h0);
        xact(6'd8, 1'b1, 1'b1, 4'd1, 32'h0, 32'h11111111, 32'h22222222, 32'h0);
        xact(6'd9, 1'b0, 1'b0, 4'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        xact(6'd9, 1'b0, 1'b0, 4'd2, 32'h0, 32'h0, 32'h0, 32'h0);
        xact(6'd15, 1'b0, 1'b0, 4'd3, 32'h0, 32'h0, 32'h0, 32'h000000FF);
        // Back-to-back, no bubbles; includes an LDW to the top even register
        xact(6'd1, 1'b1, 1'b1, 4'd5, 32'hDEAD0001, 32'hBEEF0002, 32'h0, 32'h0);
        xact(6'd2, 1'b1, 1'b0, 4'd6, 32'hCAFE0003, 32'h0, 32'h0, 32'h0);
        xact(6'd8, 1'b1, 1'b1, 4'd14, 32'h0, 32'h0E0E0E0E, 32'h0F0F0F0F, 32'h0);

        // Reset during the high-word cycle of LDW rd=4 aborts the R5 write
        drive(6'd8, 1'b1, 1'b1, 4'd4, 32'h0, 32'h44444444, 32'h55555555, 32'h0);
        tick();
        expect_out("rst_ldw_lo", 1'b1, 4'd4, 32'h44444444, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb_valid = 1'b0;
        expect_out("rst_in_hi", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_in_hi.rd", {28'd0, rd}, 32'd0);
        chk("rst_in_hi.write_data", write_data, 32'd0);
        tick();
        expect_out("rst_after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                case ($urandom_range(0, 3))
                    0:       opc = 6'd8;
                    1:       opc = 6'd9;
                    2:       opc = 6'd15;
                    default: opc = 6'($urandom_range(0, 15));
                endcase
                xact(opc, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom,
                     $urandom, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
